// File: rtl/jtag_pkg.sv
// Shared TAP state encodings and instruction codes for the JTAG controller
// and the downstream instruction decoder.
package jtag_pkg;

  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  localparam logic [1:0] EXTEST         = 2'd0;
  localparam logic [1:0] SAMPLE_PRELOAD = 2'd1;
  localparam logic [1:0] INTEST         = 2'd2;
  localparam logic [1:0] BYPASS         = 2'd3;

  localparam logic [1:0] IR_RESET   = BYPASS;
  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register plus TMS-driven next-state logic.
module tap_fsm (
  input  logic       TCK,
  input  logic       reset,
  input  logic       TMS,
  output logic [3:0] state
);
  import jtag_pkg::*;

  logic [3:0] next_state;

  always_ff @(posedge TCK) begin
    if (reset) state <= TLR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:    next_state = TMS ? TLR    : RTI;
      RTI:    next_state = TMS ? SEL_DR : RTI;
      SEL_DR: next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR: next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:  next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR: next_state = TMS ? UPD_DR : PAU_DR;
      PAU_DR: next_state = TMS ? EX2_DR : PAU_DR;
      EX2_DR: next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR: next_state = TMS ? SEL_DR : RTI;
      SEL_IR: next_state = TMS ? TLR    : CAP_IR;
      CAP_IR: next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:  next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR: next_state = TMS ? UPD_IR : PAU_IR;
      PAU_IR: next_state = TMS ? EX2_IR : PAU_IR;
      EX2_IR: next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR: next_state = TMS ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP controller: sequences the FSM, owns the IR and bypass register,
// and drives the BSR enables and the TDO mux.
module jtag_tap_controller (
  input  logic       TCK,
  input  logic       reset,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       BSR_TDO,
  output logic       TDO,
  output logic       TDO_en,
  output logic [1:0] instruction,
  output logic       CaptureDR,
  output logic       ShiftDR,
  output logic       UpdateDR,
  output logic [3:0] state
);
  import jtag_pkg::*;

  logic [1:0] ir_sh;
  logic       bypass_reg;
  logic       bsr_active;

  tap_fsm u_fsm (
    .TCK   (TCK),
    .reset (reset),
    .TMS   (TMS),
    .state (state)
  );

  always_ff @(posedge TCK) begin
    if (reset) begin
      ir_sh <= IR_CAPTURE;
    end else begin
      case (state)
        CAP_IR:  ir_sh <= IR_CAPTURE;
        SH_IR:   ir_sh <= {TDI, ir_sh[1]};
        default: ir_sh <= ir_sh;
      endcase
    end
  end

  // New instruction only takes effect on the edge that leaves Update-IR.
  always_ff @(posedge TCK) begin
    if (reset)                instruction <= IR_RESET;
    else if (state == TLR)    instruction <= IR_RESET;
    else if (state == UPD_IR) instruction <= ir_sh;
  end

  always_ff @(posedge TCK) begin
    if (reset)                                       bypass_reg <= 1'b0;
    else if (state == CAP_DR)                        bypass_reg <= 1'b0;
    else if (state == SH_DR && instruction == BYPASS) bypass_reg <= TDI;
  end

  assign bsr_active = (instruction != BYPASS);

  always_comb begin
    CaptureDR = 1'b0;
    ShiftDR   = 1'b0;
    UpdateDR  = 1'b0;
    TDO_en    = 1'b0;
    TDO       = 1'b0;
    case (state)
      CAP_DR: CaptureDR = bsr_active;
      SH_DR: begin
        ShiftDR = bsr_active;
        TDO_en  = 1'b1;
        TDO     = bsr_active ? BSR_TDO : bypass_reg;
      end
      UPD_DR: UpdateDR = bsr_active;
      SH_IR: begin
        TDO_en = 1'b1;
        TDO    = ir_sh[0];
      end
      default: ;
    endcase
  end

endmodule
